// File: rtl/prim_secded_pkg.sv
// Hsiao SECDED helpers: H-matrix column generator, full matrix builder and the
// bound on how many data bits a given number of check bits can cover.
package prim_secded_pkg;

  localparam int MAX_ECC_W  = 12;
  localparam int MAX_DATA_W = 256;

  typedef logic [MAX_ECC_W-1:0]                  hsiao_col_t;
  typedef logic [MAX_ECC_W-1:0][MAX_DATA_W-1:0] hsiao_mat_t;

  function automatic int secded_binom(input int n, input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Odd-weight columns only: weight-3 first, then weight-5.
  function automatic int secded_hsiao_max_data(input int ecc_w);
    return secded_binom(ecc_w, 3) + secded_binom(ecc_w, 5);
  endfunction

  function automatic hsiao_col_t secded_hsiao_col(input int idx, input int ecc_w);
    hsiao_col_t col;
    int         n;
    col = '0;
    n   = 0;
    for (int a = 0; a < ecc_w; a++)
      for (int b = a + 1; b < ecc_w; b++)
        for (int c = b + 1; c < ecc_w; c++) begin
          if (n == idx)
            col = (hsiao_col_t'(1) << a) | (hsiao_col_t'(1) << b) | (hsiao_col_t'(1) << c);
          n++;
        end
    for (int a = 0; a < ecc_w; a++)
      for (int b = a + 1; b < ecc_w; b++)
        for (int c = b + 1; c < ecc_w; c++)
          for (int d = c + 1; d < ecc_w; d++)
            for (int e = d + 1; e < ecc_w; e++) begin
              if (n == idx)
                col = (hsiao_col_t'(1) << a) | (hsiao_col_t'(1) << b) |
                      (hsiao_col_t'(1) << c) | (hsiao_col_t'(1) << d) |
                      (hsiao_col_t'(1) << e);
              n++;
            end
    return col;
  endfunction

  // Row j of the result is the set of data bits feeding check bit j.
  function automatic hsiao_mat_t secded_hsiao_matrix(input int data_w, input int ecc_w);
    hsiao_mat_t m;
    hsiao_col_t col;
    m = '0;
    for (int i = 0; i < data_w; i++) begin
      col = secded_hsiao_col(i, ecc_w);
      for (int j = 0; j < ecc_w; j++) m[j][i] = col[j];
    end
    return m;
  endfunction

endpackage

// File: rtl/prim_secded_pipe_stage.sv
// Valid/ready register slice: accepts whenever empty or the downstream drains it,
// so a chain of these sustains one beat per cycle.
module prim_secded_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         vld_q;
  logic [W-1:0] data_q;

  assign ready_o = !vld_q || ready_i;
  assign valid_o = vld_q;
  assign data_o  = data_q;

  // Payload only loads on a real beat so the output stays 0 until the first one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (ready_o) begin
      vld_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

endmodule

// File: rtl/prim_secded_hsiao_enc_pipe.sv
// Pipelined Hsiao SECDED encoder with valid/ready on both sides and a saturating
// word counter. Define SECDED_ERR_INJ_EN to enable codeword error injection.
module prim_secded_hsiao_enc_pipe
  import prim_secded_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ECC_W  = 8,
  parameter int PIPE   = 1,
  parameter int CNT_W  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [DATA_W+ECC_W-1:0]  data_o,
  input  logic                     clr_cnt_i,
  output logic [CNT_W-1:0]         word_cnt_o,
  input  logic                     inj_en_i,
  input  logic [DATA_W+ECC_W-1:0]  inj_mask_i
);

  localparam int         CW_W     = DATA_W + ECC_W;
  localparam int         MAX_DATA = secded_hsiao_max_data(ECC_W);
  localparam hsiao_mat_t HMAT     = secded_hsiao_matrix(DATA_W, ECC_W);

  if (ECC_W > MAX_ECC_W || DATA_W > MAX_DATA_W) begin : g_err_size
    $error("prim_secded_hsiao_enc_pipe: DATA_W/ECC_W exceed package limits");
  end
  if (DATA_W > MAX_DATA) begin : g_err_bound
    $error("prim_secded_hsiao_enc_pipe: C(ECC_W,3)+C(ECC_W,5) < DATA_W");
  end
  if (PIPE != 1 && PIPE != 2) begin : g_err_pipe
    $error("prim_secded_hsiao_enc_pipe: PIPE must be 1 or 2");
  end

  function automatic logic [ECC_W-1:0] hsiao_ecc(input logic [DATA_W-1:0] d);
    logic [ECC_W-1:0] e;
    for (int j = 0; j < ECC_W; j++) e[j] = ^(d & HMAT[j][DATA_W-1:0]);
    return e;
  endfunction

`ifdef SECDED_ERR_INJ_EN
  logic [CW_W-1:0] inj_vec;
  assign inj_vec = inj_en_i ? inj_mask_i : '0;
`else
  logic unused_inj;
  assign unused_inj = ^{inj_en_i, inj_mask_i};
`endif

  if (PIPE == 1) begin : g_pipe1
    logic [CW_W-1:0] cw_p0;
`ifdef SECDED_ERR_INJ_EN
    assign cw_p0 = {hsiao_ecc(data_i), data_i} ^ inj_vec;
`else
    assign cw_p0 = {hsiao_ecc(data_i), data_i};
`endif

    // stage p1: finished codeword
    prim_secded_pipe_stage #(.W(CW_W)) u_stage_p1 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (cw_p0),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o)
    );
  end else begin : g_pipe2
    localparam logic [DATA_W-1:0] LO_MASK = {DATA_W{1'b1}} >> (DATA_W - DATA_W / 2);

    logic                 vld_p1;
    logic                 rdy_p1;
    logic [DATA_W-1:0]    data_p1;
    logic [ECC_W-1:0]     ecc_lo_p1;
    logic [ECC_W-1:0]     ecc_hi_p1;
    logic [CW_W-1:0]      cw_p1;
`ifdef SECDED_ERR_INJ_EN
    localparam int P1_W = CW_W + DATA_W + 2 * ECC_W;
    logic [P1_W-1:0] pl_p0;
    logic [P1_W-1:0] pl_p1;
    logic [CW_W-1:0] inj_p1;
    assign pl_p0 = {inj_vec, hsiao_ecc(data_i & LO_MASK), hsiao_ecc(data_i & ~LO_MASK), data_i};
    assign {inj_p1, ecc_lo_p1, ecc_hi_p1, data_p1} = pl_p1;
    assign cw_p1 = {ecc_lo_p1 ^ ecc_hi_p1, data_p1} ^ inj_p1;
`else
    localparam int P1_W = DATA_W + 2 * ECC_W;
    logic [P1_W-1:0] pl_p0;
    logic [P1_W-1:0] pl_p1;
    assign pl_p0 = {hsiao_ecc(data_i & LO_MASK), hsiao_ecc(data_i & ~LO_MASK), data_i};
    assign {ecc_lo_p1, ecc_hi_p1, data_p1} = pl_p1;
    assign cw_p1 = {ecc_lo_p1 ^ ecc_hi_p1, data_p1};
`endif

    // stage p1: data, injection vector and the two half-word partial syndromes
    prim_secded_pipe_stage #(.W(P1_W)) u_stage_p1 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (pl_p0),
      .valid_o (vld_p1),
      .ready_i (rdy_p1),
      .data_o  (pl_p1)
    );

    // stage p2: combined codeword
    prim_secded_pipe_stage #(.W(CW_W)) u_stage_p2 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (vld_p1),
      .ready_o (rdy_p1),
      .data_i  (cw_p1),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o)
    );
  end

  // Clear wins over a coincident handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      word_cnt_o <= '0;
    end else if (valid_o && ready_i && (word_cnt_o != {CNT_W{1'b1}})) begin
      word_cnt_o <= word_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_prim_secded_hsiao_enc_pipe.sv
// Scoreboard bench: directed 64/8 cases (PIPE 1 and 2) plus randomized 32/7 traffic
// on PIPE 1 and 2, checked against an independently enumerated Hsiao model.
module tb_prim_secded_hsiao_enc_pipe;

`ifdef SECDED_ERR_INJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif
  localparam int N_RAND = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst2_n;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] col8 [64];
  logic [6:0] col7 [32];

  // Columns come from walking every ecc_w-bit value downward and bit-reversing
  // those of the wanted weight: that ordering equals lexicographic index order.
  function automatic logic [7:0] ref_col(input int idx, input int ecc_w);
    int         n = 0;
    logic [7:0] r = '0;
    for (int w = 3; w <= 5; w += 2)
      for (int v = (1 << ecc_w) - 1; v >= 0; v--)
        if ($countones(v) == w) begin
          if (n == idx)
            for (int b = 0; b < ecc_w; b++)
              if (((v >> b) & 1) == 1) r = r | (8'd1 << (ecc_w - 1 - b));
          n++;
        end
    return r;
  endfunction

  function automatic logic [71:0] model64(input logic [63:0] d, input logic en, input logic [71:0] m);
    logic [7:0]  e = '0;
    logic [71:0] r;
    for (int i = 0; i < 64; i++) if (d[i]) e = e ^ col8[i];
    r = {e, d};
    if (INJ && en) r = r ^ m;
    return r;
  endfunction

  function automatic logic [38:0] model32(input logic [31:0] d, input logic en, input logic [38:0] m);
    logic [6:0]  e = '0;
    logic [38:0] r;
    for (int i = 0; i < 32; i++) if (d[i]) e = e ^ col7[i];
    r = {e, d};
    if (INJ && en) r = r ^ m;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur", nm);
  endtask

  // d1: 64/8, PIPE=1, CNT_W=4
  logic        v1, rdy1, vo1, ri1, clr1, inje1;
  logic [63:0] dd1;
  logic [71:0] do1, injm1;
  logic [3:0]  cnt1;
  logic [71:0] q1 [$];

  prim_secded_hsiao_enc_pipe #(.DATA_W(64), .ECC_W(8), .PIPE(1), .CNT_W(4)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v1), .ready_o(rdy1), .data_i(dd1),
    .valid_o(vo1), .ready_i(ri1), .data_o(do1), .clr_cnt_i(clr1), .word_cnt_o(cnt1),
    .inj_en_i(inje1), .inj_mask_i(injm1)
  );

  // d2: 64/8, PIPE=2, CNT_W=32
  logic        v2, rdy2, vo2, ri2, clr2, inje2;
  logic [63:0] dd2;
  logic [71:0] do2, injm2;
  logic [31:0] cnt2;
  logic [71:0] q2 [$];

  prim_secded_hsiao_enc_pipe #(.DATA_W(64), .ECC_W(8), .PIPE(2), .CNT_W(32)) u_d2 (
    .clk_i(clk), .rst_ni(rst2_n), .valid_i(v2), .ready_o(rdy2), .data_i(dd2),
    .valid_o(vo2), .ready_i(ri2), .data_o(do2), .clr_cnt_i(clr2), .word_cnt_o(cnt2),
    .inj_en_i(inje2), .inj_mask_i(injm2)
  );

  // random: 32/7, PIPE = k+1
  logic        vr [2];
  logic        rdyr [2];
  logic        vor [2];
  logic        rir [2];
  logic        clrr [2];
  logic        injer [2];
  logic [31:0] dr [2];
  logic [38:0] dor [2];
  logic [38:0] injmr [2];
  logic [31:0] cntr [2];
  logic [38:0] qr [2][$];
  int          nout [2] = '{0, 0};

  for (genvar k = 0; k < 2; k++) begin : g_r
    prim_secded_hsiao_enc_pipe #(.DATA_W(32), .ECC_W(7), .PIPE(k + 1), .CNT_W(32)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vr[k]), .ready_o(rdyr[k]), .data_i(dr[k]),
      .valid_o(vor[k]), .ready_i(rir[k]), .data_o(dor[k]), .clr_cnt_i(clrr[k]),
      .word_cnt_o(cntr[k]), .inj_en_i(injer[k]), .inj_mask_i(injmr[k])
    );

    logic        stall = 1'b0;
    logic [38:0] hold  = '0;
    always @(negedge clk) begin
      #1;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("r_hold_valid", vor[k], 1);
          chk("r_hold_data", dor[k], hold);
        end
        if (vor[k] && rir[k]) begin
          nout[k]++;
          if (qr[k].size() == 0) fail_now("r_unexpected_beat");
          else chk("r_data", dor[k], qr[k].pop_front());
        end
        stall = vor[k] && !rir[k];
        hold  = dor[k];
      end
    end
  end

  logic        stall1 = 1'b0;
  logic [71:0] hold1  = '0;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      stall1 = 1'b0;
    end else begin
      if (stall1) chk("d1_hold_data", do1, hold1);
      if (vo1 && ri1) begin
        if (q1.size() == 0) fail_now("d1_unexpected_beat");
        else chk("d1_data", do1, q1.pop_front());
      end
      stall1 = vo1 && !ri1;
      hold1  = do1;
    end
  end

  logic        stall2 = 1'b0;
  logic [71:0] hold2  = '0;
  always @(negedge clk) begin
    #1;
    if (!rst2_n) begin
      stall2 = 1'b0;
    end else begin
      if (stall2) begin
        chk("d2_hold_valid", vo2, 1);
        chk("d2_hold_data", do2, hold2);
      end
      if (vo2 && ri2) begin
        if (q2.size() == 0) fail_now("d2_unexpected_beat");
        else chk("d2_data", do2, q2.pop_front());
      end
      stall2 = vo2 && !ri2;
      hold2  = do2;
    end
  end

  task automatic send1(input logic [63:0] d, input logic [71:0] exp,
                       input logic en, input logic [71:0] m);
    int w = 0;
    @(negedge clk);
    v1 = 1'b1; dd1 = d; inje1 = en; injm1 = m;
    #1;
    while (!rdy1 && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (rdy1) q1.push_back(exp);
    else fail_now("d1_accept_timeout");
    @(posedge clk);
    #1;
    v1 = 1'b0; inje1 = 1'b0;
  endtask

  task automatic seq_d1();
    logic [63:0] d;
    logic [71:0] inj_exp;
    send1(64'h0, 72'h0, 1'b0, '0);
    send1(64'h1, {8'h07, 64'h1}, 1'b0, '0);
    send1(64'h1 << 56, {8'h1F, 64'h1 << 56}, 1'b0, '0);
    send1(64'h1 << 55, {8'hE0, 64'h1 << 55}, 1'b0, '0);
    inj_exp = INJ ? {8'h07, 64'h0} : {8'h07, 64'h1};
    send1(64'h1, inj_exp, 1'b1, 72'h1);
    repeat (3) @(negedge clk);
    #1 chk("d1_cnt5", cnt1, 5);
    @(negedge clk); clr1 = 1'b1;
    @(negedge clk); clr1 = 1'b0;
    #1 chk("d1_cnt_clear", cnt1, 0);
    for (int i = 0; i < 17; i++) begin
      d = {$urandom, $urandom};
      send1(d, model64(d, 1'b0, '0), 1'b0, '0);
    end
    repeat (3) @(negedge clk);
    #1 chk("d1_cnt_sat", cnt1, 15);
    d = {$urandom, $urandom};
    send1(d, model64(d, 1'b0, '0), 1'b0, '0);
    @(negedge clk);
    clr1 = 1'b1;
    #1 chk("d1_clr_with_hs_valid", vo1, 1);
    @(negedge clk);
    clr1 = 1'b0;
    #1 chk("d1_clr_with_hs_cnt", cnt1, 0);
  endtask

  task automatic seq_d2();
    logic [63:0] d;
    ri2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      d = {$urandom, $urandom};
      v2 = 1'b1; dd2 = d;
      #1 chk("d2_ready_before_full", rdy2, 1);
      q2.push_back(model64(d, 1'b0, '0));
    end
    @(negedge clk);
    d = {$urandom, $urandom};
    dd2 = d;
    #1 chk("d2_ready_full", rdy2, 0);
    @(negedge clk);
    ri2 = 1'b1;
    #1 chk("d2_ready_release", rdy2, 1);
    q2.push_back(model64(d, 1'b0, '0));
    @(negedge clk);
    d = {$urandom, $urandom};
    dd2 = d;
    #1 chk("d2_ready_stream", rdy2, 1);
    q2.push_back(model64(d, 1'b0, '0));
    @(posedge clk);
    #1 v2 = 1'b0;
    repeat (6) @(negedge clk);
    #1 chk("d2_cnt4", cnt2, 4);

    ri2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      d = {$urandom, $urandom};
      v2 = 1'b1; dd2 = d;
      #1 chk("d2_inflight_accept", rdy2, 1);
      q2.push_back(model64(d, 1'b0, '0));
    end
    @(posedge clk);
    #1 v2 = 1'b0;
    @(negedge clk);
    #2 rst2_n = 1'b0;
    q2.delete();
    #1;
    chk("d2_rst_valid", vo2, 0);
    chk("d2_rst_cnt", cnt2, 0);
    chk("d2_rst_data", do2, 0);
    @(negedge clk);
    @(negedge clk);
    rst2_n = 1'b1;
    ri2 = 1'b1;
    @(negedge clk);
    d = {$urandom, $urandom};
    v2 = 1'b1; dd2 = d;
    #1 chk("d2_post_rst_ready", rdy2, 1);
    q2.push_back(model64(d, 1'b0, '0));
    @(posedge clk);
    #1 v2 = 1'b0;
    @(negedge clk);
    #1 chk("d2_lat_not_yet", vo2, 0);
    @(negedge clk);
    #1 chk("d2_lat2_valid", vo2, 1);
    repeat (3) @(negedge clk);
    #1 chk("d2_cnt_after_rst", cnt2, 1);
  endtask

  task automatic rand_drive(input int k);
    int          sent = 0;
    int          cyc  = 0;
    logic [63:0] m;
    while (sent < N_RAND && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      rir[k]   = ($urandom_range(0, 3) != 0);
      vr[k]    = ($urandom_range(0, 2) != 0);
      dr[k]    = $urandom;
      injer[k] = ($urandom_range(0, 7) == 0);
      m        = {$urandom, $urandom};
      injmr[k] = m[38:0];
      #1;
      if (vr[k] && rdyr[k]) begin
        qr[k].push_back(model32(dr[k], injer[k], injmr[k]));
        sent++;
      end
    end
    @(negedge clk);
    vr[k]  = 1'b0;
    rir[k] = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("r_sent", sent, N_RAND);
    chk("r_cnt", cntr[k], nout[k]);
    chk("r_queue_empty", qr[k].size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) col8[i] = ref_col(i, 8);
    for (int i = 0; i < 32; i++) col7[i] = ref_col(i, 7)[6:0];
    rst_n = 1'b0; rst2_n = 1'b0;
    v1 = 1'b0; ri1 = 1'b1; clr1 = 1'b0; inje1 = 1'b0; injm1 = '0; dd1 = '0;
    v2 = 1'b0; ri2 = 1'b1; clr2 = 1'b0; inje2 = 1'b0; injm2 = '0; dd2 = '0;
    for (int k = 0; k < 2; k++) begin
      vr[k] = 1'b0; rir[k] = 1'b0; clrr[k] = 1'b0; injer[k] = 1'b0;
      injmr[k] = '0; dr[k] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_d1_valid", vo1, 0);
    chk("rst_d1_data", do1, 0);
    chk("rst_d1_cnt", cnt1, 0);
    chk("rst_d2_valid", vo2, 0);
    chk("rst_r1_valid", vor[1], 0);
    rst_n = 1'b1; rst2_n = 1'b1;
    fork
      seq_d1();
      seq_d2();
      rand_drive(0);
      rand_drive(1);
    join
    repeat (4) @(negedge clk);
    #1;
    chk("d1_queue_empty", q1.size(), 0);
    chk("d2_queue_empty", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
